// File: rtl/peripheral_irq_defs.sv
// Shared definitions for the peripheral interrupt controller.
// Holds the register offsets, the claim/complete FSM state encoding, the
// width of the source-id field and a byte-lane mask helper.
package peripheral_irq_defs;

  localparam int unsigned ID_W = 4;

  localparam logic [11:0] OFF_ENABLE  = 12'h000;
  localparam logic [11:0] OFF_PENDING = 12'h004;
  localparam logic [11:0] OFF_EDGE    = 12'h008;
  localparam logic [11:0] OFF_CLAIM   = 12'h00C;
  localparam logic [11:0] OFF_FORCE   = 12'h010;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_CLAIMED = 2'd2
  } irq_state_t;

  // Expands the 4 byte-lane strobes into a 32-bit bit mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] bs);
    return {{8{bs[3]}}, {8{bs[2]}}, {8{bs[1]}}, {8{bs[0]}}};
  endfunction

endpackage

// File: rtl/irq_priority_encoder.sv
// Combinational priority encoder for the interrupt controller.
// Ports:
//   active - masked pending vector, bit 0 has the highest priority
//   id     - index of the lowest set bit plus one, 0 when no bit is set
module irq_priority_encoder
  import peripheral_irq_defs::*;
#(
  parameter int unsigned IRQ_COUNT = 10
) (
  input  logic [IRQ_COUNT-1:0] active,
  output logic [ID_W-1:0]      id
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    id = '0;
    for (int unsigned i = IRQ_COUNT; i > 0; i--) begin
      if (active[i-1]) id = ID_W'(i);
    end
  end

endmodule

// File: rtl/peripheral_irq_controller.sv
// Peripheral-bus interrupt controller.
// Latches IRQ_COUNT source lines into pending bits (edge or level per
// source), masks them with ENABLE and presents a single registered
// interrupt line to the CPU with a claim (CLAIM read) / complete (CLAIM
// write) handshake.
// Ports:
//   clk, rst                  - clock, asynchronous active-high reset
//   peripheralBus_*           - slave side of the shared peripheral bus
//   requestOutput             - this block owns the read-data mux
//   irq_sources               - source lines, synchronous to clk
//   irq_out                   - registered interrupt request to the CPU
//   irq_id                    - claimed id in CLAIMED, else winner id
module peripheral_irq_controller
  import peripheral_irq_defs::*;
#(
  parameter logic [7:0]  ID        = 8'h04,
  parameter int unsigned IRQ_COUNT = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 peripheralBus_we,
  input  logic                 peripheralBus_oe,
  output logic                 peripheralBus_busy,
  input  logic [23:0]          peripheralBus_address,
  input  logic [3:0]           peripheralBus_byteSelect,
  input  logic [31:0]          peripheralBus_dataWrite,
  output logic [31:0]          peripheralBus_dataRead,
  output logic                 requestOutput,
  input  logic [IRQ_COUNT-1:0] irq_sources,
  output logic                 irq_out,
  output logic [ID_W-1:0]      irq_id
);

  logic                 sel, rd_en, wr_en;
  logic [11:0]          offset;
  logic [31:0]          lmask;
  logic [IRQ_COUNT-1:0] wmask, wbits;
  logic                 unused_bits;

  logic [IRQ_COUNT-1:0] enable_q, edge_q, pending_q, src_q, src_prev;
  logic [IRQ_COUNT-1:0] enable_d, edge_d, pending_d;
  logic [IRQ_COUNT-1:0] edge_set, edge_clr, claim_clr, active;
  logic                 wr_enable, wr_pending, wr_edge, wr_force;
  logic                 claim_take, complete;

  logic [ID_W-1:0]      winner_id, winner_q, claimed_id;
  irq_state_t           state_q, state_d;
  logic                 irq_out_q;
  logic [31:0]          rd_val;

  // Bus decode
  assign sel    = (peripheralBus_address[23:20] == 4'h0) &&
                  (peripheralBus_address[19:12] == ID);
  assign offset = peripheralBus_address[11:0];
  assign rd_en  = sel & peripheralBus_oe;
  assign wr_en  = sel & peripheralBus_we;

  assign requestOutput      = rd_en;
  assign peripheralBus_busy = 1'b0;

  assign lmask = lane_mask(peripheralBus_byteSelect);
  assign wmask = lmask[IRQ_COUNT-1:0];
  assign wbits = peripheralBus_dataWrite[IRQ_COUNT-1:0] & wmask;
  // Register bits above IRQ_COUNT do not exist, so those write bits are dropped.
  assign unused_bits = &{1'b0, lmask[31:IRQ_COUNT],
                         peripheralBus_dataWrite[31:IRQ_COUNT]};

  assign wr_enable  = wr_en && (offset == OFF_ENABLE);
  assign wr_pending = wr_en && (offset == OFF_PENDING);
  assign wr_edge    = wr_en && (offset == OFF_EDGE);
  assign wr_force   = wr_en && (offset == OFF_FORCE);

  // Prioritisation
  assign active = pending_q & enable_q;

  irq_priority_encoder #(
    .IRQ_COUNT(IRQ_COUNT)
  ) u_prio (
    .active(active),
    .id    (winner_id)
  );

  // A claim only succeeds while asserting with something to hand out.
  assign claim_take = rd_en && (offset == OFF_CLAIM) &&
                      (state_q == ST_ASSERT) && (active != '0);
  assign complete   = wr_en && (offset == OFF_CLAIM) &&
                      peripheralBus_byteSelect[0] &&
                      (state_q == ST_CLAIMED) &&
                      (peripheralBus_dataWrite[ID_W-1:0] == claimed_id);

  // Register next values
  always_comb begin
    enable_d = wr_enable ? ((enable_q & ~wmask) | wbits) : enable_q;
    edge_d   = wr_edge   ? ((edge_q   & ~wmask) | wbits) : edge_q;

    claim_clr = '0;
    if (claim_take) claim_clr = IRQ_COUNT'(1) << (winner_id - 1'b1);

    edge_set = (src_q & ~src_prev) | (wr_force ? wbits : '0);
    edge_clr = (wr_pending ? wbits : '0) | claim_clr;

    // Edge sources: set beats clear in the same cycle. Level sources track src_q.
    pending_d = (edge_q & ((pending_q & ~edge_clr) | edge_set)) |
                (~edge_q & src_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable_q   <= '0;
      edge_q     <= '0;
      pending_q  <= '0;
      src_q      <= '0;
      src_prev   <= '0;
      winner_q   <= '0;
      claimed_id <= '0;
      irq_out_q  <= 1'b0;
    end else begin
      enable_q   <= enable_d;
      edge_q     <= edge_d;
      pending_q  <= pending_d;
      src_q      <= irq_sources;
      src_prev   <= src_q;
      winner_q   <= winner_id;
      if (claim_take) claimed_id <= winner_id;
      irq_out_q  <= (state_q == ST_ASSERT);
    end
  end

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (active != '0) state_d = ST_ASSERT;
      ST_ASSERT: begin
        if (claim_take)         state_d = ST_CLAIMED;
        else if (active == '0)  state_d = ST_IDLE;
      end
      ST_CLAIMED: if (complete) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    irq_out = irq_out_q;
    irq_id  = (state_q == ST_CLAIMED) ? claimed_id : winner_q;
  end

  // Read data reflects pre-edge state, so a read alongside a write
  // returns the old value.
  always_comb begin
    rd_val = '0;
    case (offset)
      OFF_ENABLE:  rd_val = 32'(enable_q);
      OFF_PENDING: rd_val = 32'(pending_q);
      OFF_EDGE:    rd_val = 32'(edge_q);
      OFF_CLAIM:   rd_val = claim_take ? 32'(winner_id) : '0;
      default:     rd_val = '0;
    endcase
    peripheralBus_dataRead = rd_en ? rd_val : '0;
  end

endmodule

// File: tb/tb_peripheral_irq_controller.sv
module tb_peripheral_irq_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        we, oe, busy, req, irq_out;
  logic [23:0] addr;
  logic [3:0]  bs;
  logic [31:0] wdata, rdata;
  logic [9:0]  irq_sources;
  logic [3:0]  irq_id;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  peripheral_irq_controller #(
    .ID       (8'h04),
    .IRQ_COUNT(10)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
    .peripheralBus_we        (we),
    .peripheralBus_oe        (oe),
    .peripheralBus_busy      (busy),
    .peripheralBus_address   (addr),
    .peripheralBus_byteSelect(bs),
    .peripheralBus_dataWrite (wdata),
    .peripheralBus_dataRead  (rdata),
    .requestOutput           (req),
    .irq_sources             (irq_sources),
    .irq_out                 (irq_out),
    .irq_id                  (irq_id)
  );

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] addr_of(input logic [11:0] off);
    return {4'h0, 8'h04, off};
  endfunction

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [11:0] off, input logic [31:0] d,
                           input logic [3:0] lanes);
    @(negedge clk);
    we = 1'b1; addr = addr_of(off); wdata = d; bs = lanes;
    @(negedge clk);
    we = 1'b0; bs = 4'h0; wdata = '0;
  endtask

  task automatic rd_check(input string tag, input logic [11:0] off,
                          input logic [31:0] exp);
    @(negedge clk);
    oe = 1'b1; addr = addr_of(off);
    #1;
    check_eq(tag, rdata, exp);
    @(negedge clk);
    oe = 1'b0;
  endtask

  task automatic pulse(input logic [9:0] m);
    @(negedge clk);
    irq_sources = irq_sources | m;
    @(negedge clk);
    irq_sources = irq_sources & ~m;
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; oe = 1'b0; addr = '0; bs = '0; wdata = '0;
    irq_sources = '0;
    idle(3);
    #1;
    check_eq("rst_irq_out", irq_out, 0);
    check_eq("rst_irq_id", irq_id, 0);
    rst = 1'b0;
    idle(1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_req", req, 0);
    check_eq("rst_rdata", rdata, 0);
    rd_check("rst_enable", 12'h000, 0);
    rd_check("rst_pending", 12'h004, 0);
    rd_check("rst_edge", 12'h008, 0);
    rd_check("rst_claim", 12'h00C, 0);

    // Single edge source, latency and handshake
    bus_write(12'h000, 32'h3FF, 4'hF);
    bus_write(12'h008, 32'h3FF, 4'hF);
    @(negedge clk);
    irq_sources[5] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) irq_sources[5] = 1'b0;
      check_eq($sformatf("lat_n%0d", k), irq_out, (k == 3) ? 1 : 0);
    end
    check_eq("s5_irq_id", irq_id, 6);
    rd_check("s5_pending", 12'h004, 32'h020);
    rd_check("s5_claim", 12'h00C, 6);
    rd_check("s5_pending_after", 12'h004, 0);
    check_eq("s5_irq_low", irq_out, 0);
    check_eq("s5_claimed_id", irq_id, 6);
    bus_write(12'h00C, 32'h6, 4'hF);
    check_eq("s5_done_id", irq_id, 0);
    rd_check("s5_claim_idle", 12'h00C, 0);

    // Priority between sources 2 and 7
    pulse(10'h084);
    idle(4);
    check_eq("pri_irq", irq_out, 1);
    rd_check("pri_pending", 12'h004, 32'h084);
    rd_check("pri_claim3", 12'h00C, 3);
    bus_write(12'h00C, 32'h3, 4'hF);
    idle(3);
    check_eq("pri_reassert", irq_out, 1);
    rd_check("pri_claim8", 12'h00C, 8);
    bus_write(12'h00C, 32'h8, 4'hF);
    idle(3);
    check_eq("pri_idle", irq_out, 0);

    // Level source 0
    bus_write(12'h008, 32'h3FE, 4'hF);
    @(negedge clk);
    irq_sources[0] = 1'b1;
    idle(5);
    check_eq("lvl_irq", irq_out, 1);
    rd_check("lvl_pending", 12'h004, 32'h001);
    bus_write(12'h004, 32'h001, 4'hF);
    rd_check("lvl_w1c_nop", 12'h004, 32'h001);
    rd_check("lvl_claim", 12'h00C, 1);
    bus_write(12'h00C, 32'h1, 4'hF);
    idle(3);
    check_eq("lvl_reassert", irq_out, 1);
    irq_sources[0] = 1'b0;
    idle(5);
    check_eq("lvl_drop", irq_out, 0);
    rd_check("lvl_claim_idle", 12'h00C, 0);
    bus_write(12'h008, 32'h3FF, 4'hF);

    // Wrong-id complete
    pulse(10'h004);
    idle(4);
    rd_check("wid_claim", 12'h00C, 3);
    bus_write(12'h00C, 32'h5, 4'hF);
    check_eq("wid_still_claimed", irq_id, 3);
    rd_check("wid_claim_again", 12'h00C, 0);
    bus_write(12'h00C, 32'h3, 4'hF);
    check_eq("wid_done", irq_id, 0);

    // Disable the only active source while asserting
    pulse(10'h010);
    idle(4);
    check_eq("dis_irq", irq_out, 1);
    bus_write(12'h000, 32'h3EF, 4'hF);
    @(posedge clk);
    @(posedge clk);
    #1;
    check_eq("dis_irq_low", irq_out, 0);
    bus_write(12'h004, 32'h010, 4'hF);
    rd_check("dis_w1c", 12'h004, 0);
    bus_write(12'h000, 32'h3FF, 4'hF);

    // FORCE with byte lanes
    bus_write(12'h010, 32'h010, 4'b0010);
    rd_check("force_wrong_lane", 12'h004, 0);
    bus_write(12'h010, 32'h010, 4'b0001);
    rd_check("force_pending", 12'h004, 32'h010);
    rd_check("force_reads0", 12'h010, 0);
    idle(2);
    check_eq("force_irq", irq_out, 1);
    rd_check("force_claim", 12'h00C, 5);
    bus_write(12'h00C, 32'h5, 4'hF);

    // Byte-lane masking on ENABLE
    bus_write(12'h000, 32'h0, 4'b0010);
    rd_check("lane_clr_hi", 12'h000, 32'h0FF);
    bus_write(12'h000, 32'hFFFF_FFFF, 4'b0010);
    rd_check("lane_set_hi", 12'h000, 32'h3FF);

    // Unmapped offset and foreign device slot
    @(negedge clk);
    oe = 1'b1; addr = addr_of(12'h020);
    #1;
    check_eq("unmapped_data", rdata, 0);
    check_eq("unmapped_req", req, 1);
    addr = {4'h0, 8'h05, 12'h000};
    #1;
    check_eq("foreign_req", req, 0);
    check_eq("foreign_data", rdata, 0);
    @(negedge clk);
    oe = 1'b0;

    // Read and write to the same offset in one cycle
    @(negedge clk);
    we = 1'b1; oe = 1'b1; addr = addr_of(12'h000); wdata = 32'h155; bs = 4'hF;
    #1;
    check_eq("rw_old_value", rdata, 32'h3FF);
    @(negedge clk);
    we = 1'b0; oe = 1'b0; bs = 4'h0;
    rd_check("rw_new_value", 12'h000, 32'h155);
    bus_write(12'h000, 32'h3FF, 4'hF);

    // Reset in the middle of a handshake
    pulse(10'h002);
    idle(4);
    rd_check("mid_claim", 12'h00C, 2);
    check_eq("mid_claimed_id", irq_id, 2);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_id", irq_id, 0);
    check_eq("mid_rst_irq", irq_out, 0);
    idle(1);
    rst = 1'b0;
    rd_check("mid_rst_enable", 12'h000, 0);
    rd_check("mid_rst_claim", 12'h00C, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
